nios2_c_bidir_pio: RTL and testbench
====================================

// Module: nios2_c_bidir_pio
// PURPOSE
//  Parametrised bidirectional PIO; Avalon-MM slave on the Nios II data master.
//  Per-bit direction, atomic set/clear of output bits, 2-flop input synchroniser,
//  edge capture and optional interrupt. Drives multi-bit open buses (SD DAT[3:0], I2C, GPIO).
// PARAMETERS
//  WIDTH      4  number of pins, 1..32
//  RESET_OUT  0  reset value of data_out[WIDTH-1:0]
//  RESET_DIR  0  reset value of data_dir[WIDTH-1:0]; 1 = drive
//  EDGE_TYPE  0  captured edge: 0 = rising, 1 = falling, 2 = any
// PORTS
//  clk         in     1      system clock
//  reset_n     in     1      async active-low reset
//  address     in     3      register select
//  chipselect  in     1      slave select
//  write_n     in     1      active-low write strobe
//  writedata   in     32     write data
//  readdata    out    32     registered read data
//  bidir_port  inout  WIDTH  pins
//  irq         out    1      level interrupt, active high
// BEHAVIOUR
//  Clock/reset: single clk. reset_n is asynchronous and active-low.
//  All flops reset asynchronously.
//  Reset values:
//   - readdata = 0
//   - data_out = RESET_OUT, data_dir = RESET_DIR
//   - irq_mask = 0, edge_capture = 0
//   - sync stages = 0, prev sample = 0, irq = 0
//  Write: occurs when chipselect && !write_n at a rising clk edge.
//   - Only bits [WIDTH-1:0] of writedata are used; upper bits are ignored.
//  Register map (R = read value, W = write effect):
//   - 0 DATA: R = sync_in; W: data_out <= wd
//   - 1 DIR: R/W data_dir
//   - 2 IRQMASK: R/W irq_mask
//   - 3 EDGECAP: R = edge_capture; W: write 1 to clear each bit
//   - 4 OUTSET: R = 0; W: data_out <= data_out | wd
//   - 5 OUTCLR: R = 0; W: data_out <= data_out & ~wd
//   - 6, 7: R = 0; writes ignored
//  Pins: bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz.
//  Input path:
//   - raw -> s1 -> s2 (= sync_in) -> prev
//   - A pin change is visible in DATA reads 2 clk later.
//   - Driven pins loop back, so DATA reads return the driven value.
//  Edge detect, per bit:
//   - rise = s2 & ~prev, fall = ~s2 & prev
//   - EDGE_TYPE selects rise, fall or rise|fall.
//   - A detected edge sets edge_capture[i] in the same cycle that prev updates.
//  Simultaneous EDGECAP clear-write and a new edge on the same bit: set wins, bit stays 1.
//  Read latency:
//   - readdata <= read mux(address) on every clk, regardless of chipselect.
//   - Data is valid 1 clk after address is presented. No wait states.
//  readdata[31:WIDTH] is always 0.
//  Mid-operation reset: all registers return to reset values at once.
//   - Pins float at once wherever RESET_DIR = 0.
//  WIDTH = 32: OUTSET/OUTCLR cover the full word. No reserved bits.
// CONFIGURATION
//  Macro: NIOS2_C_BIDIR_PIO_IRQ_EN
//  Defined:
//   - irq_mask register is implemented.
//   - irq = |(edge_capture & irq_mask), registered: asserts 1 clk after the capture bit sets.
//   - irq deasserts 1 clk after the clearing write or mask write.
//  Undefined:
//   - No irq_mask flops. irq tied 0.
//   - IRQMASK reads 0 and writes are ignored.
//   - Edge capture stays functional for polling.
// TESTING (WIDTH=4, RESET_OUT=0, RESET_DIR=0, EDGE_TYPE=0)
//  1. After reset:
//     - all pins Z, irq = 0
//     - reads of addresses 1, 2, 3 return 0x0
//     - read of address 0 with pins pulled to 4'hA returns 0xA
//  2. Write DIR = 0xF, then DATA = 0x5, then OUTSET = 0x8, then OUTCLR = 0x1:
//     - pins = 4'hC after the last write
//     - DATA read returns 0xC from the 3rd clk after the last write
//     - readdata bits [31:4] = 0
//  3. Drive pin0 low->high with DIR = 0:
//     - EDGECAP[0] = 1 within 3 clk
//     - high->low transition leaves EDGECAP unchanged
//     - EDGECAP write of 0x1 clears it to 0x0
//  4. Rising edge on pin2 in the same clk as an EDGECAP write of 0x4:
//     - EDGECAP reads 0x4 afterwards (set wins)
//  5. IRQ_EN defined, IRQMASK = 0x2, edge on pin1:
//     - irq = 1 one clk after capture
//     - IRQMASK = 0 drops irq next clk
//     - IRQ_EN undefined: irq stays 0 and IRQMASK reads 0
//  6. Assert reset_n mid-run with DIR = 0xF and DATA = 0xF:
//     - pins go Z asynchronously
//     - readdata = 0 and irq = 0 during reset

Source files
------------

// File: rtl/nios2_c_bidir_pio_if.sv
// Avalon-MM slave register bus between the Nios II data master and the PIO.
// Latency: readdata is registered, valid 1 clk after address is presented.
// Backpressure: none; no waitrequest, every access completes in one cycle.
interface nios2_c_bidir_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_c_bidir_pio.sv
// Bidirectional PIO: per-bit direction, atomic set/clear, synchronised input, edge capture, irq.
// Latency: 1 clk read; pin change visible in DATA 2 clk later; edge captured 3 clk after pin change.
// Backpressure: none; slave accepts every access, no wait states. Optional irq: NIOS2_C_BIDIR_PIO_IRQ_EN.
module nios2_c_bidir_pio #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '0,
    parameter int               EDGE_TYPE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    nios2_c_bidir_pio_if.slave  bus,
    inout  wire  [WIDTH-1:0]    bidir_port,
    output logic                irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_dir;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] pin_raw;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wr_dat;
    logic             wr_vld;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;
    logic [31:0]      writedata_unused;

    // Only the low WIDTH bits of a write carry meaning; the rest are dropped.
    assign wr_vld           = bus.chipselect && !bus.write_n;
    assign wr_dat           = bus.writedata[WIDTH-1:0];
    assign writedata_unused = bus.writedata;

    // Each pin is driven only while its direction bit is set; otherwise it floats.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
    end

    // Driven pins loop back through here, so DATA reads return the driven level.
    assign pin_raw = bidir_port;

    // Two-flop synchroniser plus one history stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '0;
            sync_in <= '0;
            prev_in <= '0;
        end else begin
            sync_s1 <= pin_raw;
            sync_in <= sync_s1;
            prev_in <= sync_in;
        end
    end

    // Select which transitions count as an event.
    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = sync_in & ~prev_in;
            1:       edge_hit = ~sync_in & prev_in;
            default: edge_hit = (sync_in & ~prev_in) | (~sync_in & prev_in);
        endcase
    end

    // Output data and direction, including atomic set/clear of output bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_OUT;
            data_dir <= RESET_DIR;
        end else if (wr_vld) begin
            case (bus.address)
                ADDR_DATA:   data_out <= wr_dat;
                ADDR_DIR:    data_dir <= wr_dat;
                ADDR_OUTSET: data_out <= data_out | wr_dat;
                ADDR_OUTCLR: data_out <= data_out & ~wr_dat;
                default:     ;
            endcase
        end
    end

    // Sticky edge capture, write-1-to-clear; a fresh edge beats a clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else if (wr_vld && bus.address == ADDR_EDGECAP) begin
            edge_capture <= (edge_capture & ~wr_dat) | edge_hit;
        end else begin
            edge_capture <= edge_capture | edge_hit;
        end
    end

`ifdef NIOS2_C_BIDIR_PIO_IRQ_EN
    logic [WIDTH-1:0] irq_mask;

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_vld && bus.address == ADDR_IRQMASK) begin
            irq_mask <= wr_dat;
        end
    end

    // Registered level interrupt: follows capture/mask changes one clk later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end
`else
    // Without interrupt support software polls EDGECAP instead.
    assign irq = 1'b0;
`endif

    // Read mux; unused addresses and bits above WIDTH read as zero.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
            ADDR_DIR:     rd_mux[WIDTH-1:0] = data_dir;
`ifdef NIOS2_C_BIDIR_PIO_IRQ_EN
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
`endif
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
            default:      rd_mux = '0;
        endcase
    end

    // readdata is refreshed every clk whether or not the slave is selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= rd_mux;
        end
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_nios2_c_bidir_pio.sv
// Bench for nios2_c_bidir_pio (WIDTH=4, rising-edge capture); vectors plus corner sequences.
// Latency: reads scored 1 clk after address; input path checked at its 2/3-clk boundaries.
// Backpressure: none exercised; the slave has no wait states.
module tb_nios2_c_bidir_pio;

`ifdef NIOS2_C_BIDIR_PIO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    wire  [3:0] pins;
    logic       irq;
    logic [3:0] tb_oe;
    logic [3:0] tb_val;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_exp[$];
    string       sb_name[$];

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] dat;
        int          idle;
    } vec_t;

    vec_t vt[18];

    nios2_c_bidir_pio_if bus();

    nios2_c_bidir_pio #(
        .WIDTH     (4),
        .RESET_OUT (4'h0),
        .RESET_DIR (4'h0),
        .EDGE_TYPE (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .bidir_port (pins),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        string       n;
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        e = sb_exp.pop_front();
        n = sb_name.pop_front();
        chk(n, bus.readdata, e);
    endtask

    initial begin
        reset_n        = 1'b0;
        tb_oe          = 4'h0;
        tb_val         = 4'h0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        // Register-level vectors: writes carry write data, reads carry expected data.
        vt[0]  = '{1'b1, 3'd1, 32'h0000_000F, 0};
        vt[1]  = '{1'b0, 3'd1, 32'h0000_000F, 0};
        vt[2]  = '{1'b1, 3'd0, 32'h0000_0005, 0};
        vt[3]  = '{1'b1, 3'd4, 32'h0000_0008, 0};
        vt[4]  = '{1'b1, 3'd5, 32'h0000_0001, 0};
        vt[5]  = '{1'b0, 3'd0, 32'h0000_000C, 2};
        vt[6]  = '{1'b0, 3'd2, 32'h0000_0000, 0};
        vt[7]  = '{1'b0, 3'd4, 32'h0000_0000, 0};
        vt[8]  = '{1'b0, 3'd5, 32'h0000_0000, 0};
        vt[9]  = '{1'b1, 3'd6, 32'h0000_00FF, 0};
        vt[10] = '{1'b0, 3'd1, 32'h0000_000F, 0};
        vt[11] = '{1'b0, 3'd6, 32'h0000_0000, 0};
        vt[12] = '{1'b0, 3'd7, 32'h0000_0000, 0};
        vt[13] = '{1'b1, 3'd0, 32'hFFFF_FFF3, 0};
        vt[14] = '{1'b0, 3'd0, 32'h0000_0003, 2};
        vt[15] = '{1'b1, 3'd4, 32'hFFFF_FFFC, 0};
        vt[16] = '{1'b1, 3'd5, 32'hFFFF_FF03, 0};
        vt[17] = '{1'b0, 3'd0, 32'h0000_000C, 2};

        #22;
        reset_n = 1'b1;
        #1;
        chk("reset_readdata", bus.readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // Reset state reads, then input path with pins pulled to 0xA.
        do_read(3'd1, 32'h0, "rst_dir");
        do_read(3'd2, 32'h0, "rst_irqmask");
        do_read(3'd3, 32'h0, "rst_edgecap");
        tb_oe  = 4'hF;
        tb_val = 4'hA;
        #1;
        chk("rst_pins_released", {28'h0, pins}, 32'hA);
        repeat (2) @(posedge clk);
        do_read(3'd0, 32'hA, "rst_data_in");
        tb_oe = 4'h0;

        for (int i = 0; i < 18; i++) begin
            repeat (vt[i].idle) @(posedge clk);
            if (vt[i].wr) do_write(vt[i].addr, vt[i].dat);
            else          do_read(vt[i].addr, vt[i].dat, $sformatf("vec%0d", i));
        end
        chk("pins_driven_c", {28'h0, pins}, 32'hC);

        do_write(3'd1, 32'hFFFF_FFF0);
        do_read(3'd1, 32'h0, "dir_upper_ignored");

        // Rising edge captured, falling edge ignored, write-1-to-clear.
        tb_val = 4'h0;
        tb_oe  = 4'hF;
        repeat (4) @(posedge clk);
        do_write(3'd3, 32'hF);
        do_read(3'd3, 32'h0, "ec_clear_all");
        @(negedge clk);
        tb_val[0] = 1'b1;
        repeat (3) @(posedge clk);
        do_read(3'd3, 32'h1, "ec_rise0");
        @(negedge clk);
        tb_val[0] = 1'b0;
        repeat (4) @(posedge clk);
        do_read(3'd3, 32'h1, "ec_fall_ignored");
        do_write(3'd3, 32'h1);
        do_read(3'd3, 32'h0, "ec_w1c");
        @(negedge clk);
        tb_val[3] = 1'b1;
        repeat (4) @(posedge clk);
        do_write(3'd3, 32'h7);
        do_read(3'd3, 32'h8, "ec_w1c_partial");
        do_write(3'd3, 32'h8);

        // Edge on pin2 lands in the same clk as its clear: set wins.
        @(negedge clk);
        tb_val[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        do_write(3'd3, 32'h4);
        do_read(3'd3, 32'h4, "ec_set_wins");
        do_write(3'd3, 32'h4);
        do_read(3'd3, 32'h0, "ec_clear_after");

        // Interrupt path.
        do_write(3'd2, 32'h2);
        do_read(3'd2, {30'h0, IRQ_ON, 1'b0}, "irqmask_rb");
        chk("irq_idle", {31'h0, irq}, 32'h0);
        @(negedge clk);
        tb_val[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_at_capture", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("irq_assert", {31'h0, irq}, {31'h0, IRQ_ON});
        do_write(3'd2, 32'h0);
        chk("irq_hold_on_mask_write", {31'h0, irq}, {31'h0, IRQ_ON});
        @(posedge clk);
        #1;
        chk("irq_mask_drop", {31'h0, irq}, 32'h0);
        do_write(3'd2, 32'h2);
        @(posedge clk);
        #1;
        chk("irq_reassert", {31'h0, irq}, {31'h0, IRQ_ON});
        do_write(3'd3, 32'h2);
        @(posedge clk);
        #1;
        chk("irq_clear_drop", {31'h0, irq}, 32'h0);
        @(negedge clk);
        tb_val[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tb_val[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("irq_pre_reset", {31'h0, irq}, {31'h0, IRQ_ON});

        // Mid-run reset while driving 0xF.
        tb_oe = 4'h0;
        do_write(3'd1, 32'hF);
        do_write(3'd0, 32'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("pins_drive_f", {28'h0, pins}, 32'hF);
        do_read(3'd1, 32'hF, "dir_before_reset");
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_readdata", bus.readdata, 32'h0);
        chk("reset_mid_irq", {31'h0, irq}, 32'h0);
        tb_val = 4'h0;
        tb_oe  = 4'hF;
        #1;
        chk("reset_mid_pins_float", {28'h0, pins}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_hold_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        do_read(3'd1, 32'h0, "post_reset_dir");
        do_read(3'd3, 32'h0, "post_reset_edgecap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
